// File: rtl/filter_window_sequencer_pkg.sv
// filt_seq_pkg: shared constants for the 3x3 window sequencer.
//   PIX_W / WIN_W     : pixel and packed-window widths (RGB444, 9 slots)
//   SLOT_*            : read/pack order, original first, downright last
//   slot_lsb()        : bit offset of a slot inside the window, (8-slot)*PIX_W
//   slot_dx/slot_dy() : neighbour step per slot
//   state_t           : sequencer FSM states (legacy encodings S_*)
package filt_seq_pkg;

  localparam int unsigned PIX_W = 12;
  localparam int unsigned WIN_W = 108;

  localparam logic [3:0] SLOT_ORIG = 4'd0;
  localparam logic [3:0] SLOT_L    = 4'd1;
  localparam logic [3:0] SLOT_R    = 4'd2;
  localparam logic [3:0] SLOT_U    = 4'd3;
  localparam logic [3:0] SLOT_D    = 4'd4;
  localparam logic [3:0] SLOT_UL   = 4'd5;
  localparam logic [3:0] SLOT_UR   = 4'd6;
  localparam logic [3:0] SLOT_DL   = 4'd7;
  localparam logic [3:0] SLOT_DR   = 4'd8;

  typedef enum logic [1:0] {
    STEP_ZERO = 2'd0,
    STEP_NEG  = 2'd1,
    STEP_POS  = 2'd2
  } step_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CAP   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_FETCH = S_FETCH,
    ST_CAP   = S_CAP,
    ST_WAIT  = S_WAIT,
    ST_WRITE = S_WRITE,
    ST_DONE  = S_DONE
  } state_t;

  function automatic int unsigned slot_lsb(input logic [3:0] s);
    return (32'd8 - 32'(s)) * PIX_W;
  endfunction

  function automatic step_t slot_dx(input logic [3:0] s);
    case (s)
      SLOT_L, SLOT_UL, SLOT_DL: return STEP_NEG;
      SLOT_R, SLOT_UR, SLOT_DR: return STEP_POS;
      default:                  return STEP_ZERO;
    endcase
  endfunction

  function automatic step_t slot_dy(input logic [3:0] s);
    case (s)
      SLOT_U, SLOT_UL, SLOT_UR: return STEP_NEG;
      SLOT_D, SLOT_DL, SLOT_DR: return STEP_POS;
      default:                  return STEP_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/filter_window_sequencer_addr_gen.sv
// seq_addr_gen: clamped neighbour address for the current pixel and slot.
//   clk, reset        : clock, asynchronous active-high reset
//   row_clr, row_inc  : clear / advance the row base (y*IMG_W) by one row
//   x, y, slot        : current pixel and neighbour slot
//   src_addr          : clamped neighbour address (edge replication)
//   row_base          : y*IMG_W, maintained incrementally
module seq_addr_gen
  import filt_seq_pkg::*;
#(
  parameter int unsigned IMG_W  = 160,
  parameter int unsigned IMG_H  = 120,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned XW     = 8,
  parameter int unsigned YW     = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              row_clr,
  input  logic              row_inc,
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  input  logic [3:0]        slot,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] row_base
);

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  logic [XW-1:0]     nx;
  logic [ADDR_W-1:0] nrow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        row_base <= '0;
    else if (row_clr) row_base <= '0;
    else if (row_inc) row_base <= row_base + ROW_STEP;
  end

  // Neighbour rows are reached by +/- one row step from the base, so the
  // clamp only has to suppress that step at the top/bottom edge.
  always_comb begin
    nx = x;
    case (slot_dx(slot))
      STEP_NEG: if (x != '0) nx = x - 1'b1;
      STEP_POS: if (x != XW'(IMG_W - 1)) nx = x + 1'b1;
      default:  ;
    endcase
    nrow = row_base;
    case (slot_dy(slot))
      STEP_NEG: if (y != '0) nrow = row_base - ROW_STEP;
      STEP_POS: if (y != YW'(IMG_H - 1)) nrow = row_base + ROW_STEP;
      default:  ;
    endcase
    src_addr = nrow + ADDR_W'(nx);
  end

endmodule

// File: rtl/filter_window_sequencer.sv
// filter_window_sequencer: walks a frame pixel by pixel, fetches the 3x3
// neighbourhood from the source RAM into a 108-bit window, waits the effect
// latency and writes the effect result to the destination RAM.
//   clk, reset            : clock, asynchronous active-high reset
//   start / busy / done   : frame control (start sampled only in IDLE)
//   src_rd/src_addr/src_data : source RAM read port (1-cycle read latency)
//   win_data / win_valid  : packed window toward the effect stage
//   filt_rgb_in           : effect result, valid FILTER_LAT cycles after win_valid
//   dst_we/dst_addr/dst_data : destination RAM write port
// Optional: `define SEQ_ABORT_EN adds abort (input) and aborted (output).
module filter_window_sequencer
  import filt_seq_pkg::*;
#(
  parameter int unsigned IMG_W      = 160,
  parameter int unsigned IMG_H      = 120,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned FILTER_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [11:0]       src_data,
  output logic [107:0]      win_data,
  output logic              win_valid,
  input  logic [11:0]       filt_rgb_in,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [11:0]       dst_data
`ifdef SEQ_ABORT_EN
  ,
  input  logic              abort,
  output logic              aborted
`endif
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(FILTER_LAT + 1);

  state_t            state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [3:0]        k;
  logic [CW-1:0]     wcnt;
  logic [ADDR_W-1:0] gen_addr;
  logic [ADDR_W-1:0] row_base;
  logic              abort_i;
  logic              last_x;
  logic              last_y;
  logic              row_clr;
  logic              row_inc;

`ifdef SEQ_ABORT_EN
  assign abort_i = abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) aborted <= 1'b0;
    else       aborted <= abort && (state != ST_IDLE);
  end
`else
  assign abort_i = 1'b0;
`endif

  assign last_x  = (x == XW'(IMG_W - 1));
  assign last_y  = (y == YW'(IMG_H - 1));
  assign row_clr = (state == ST_IDLE) && start;
  assign row_inc = (state == ST_WRITE) && last_x && !abort_i;

  seq_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .XW    (XW),
    .YW    (YW)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .row_clr (row_clr),
    .row_inc (row_inc),
    .x       (x),
    .y       (y),
    .slot    (k),
    .src_addr(gen_addr),
    .row_base(row_base)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      x        <= '0;
      y        <= '0;
      k        <= '0;
      wcnt     <= '0;
      win_data <= '0;
    end else if (abort_i && state != ST_IDLE) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_FETCH;
            x     <= '0;
            y     <= '0;
            k     <= '0;
          end
        end
        ST_FETCH: begin
          // Read data trails the strobe by one cycle: capture slot k-1 now.
          if (k != '0) win_data[slot_lsb(k - 4'd1) +: PIX_W] <= src_data;
          k <= k + 1'b1;
          if (k == SLOT_DR) state <= ST_CAP;
        end
        ST_CAP: begin
          win_data[slot_lsb(SLOT_DR) +: PIX_W] <= src_data;
          wcnt  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wcnt == CW'(FILTER_LAT - 1)) state <= ST_WRITE;
          else                             wcnt  <= wcnt + 1'b1;
        end
        ST_WRITE: begin
          k <= '0;
          if (last_x) begin
            x <= '0;
            y <= y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
          state <= (last_x && last_y) ? ST_DONE : ST_FETCH;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state == ST_FETCH) || (state == ST_CAP) ||
                (state == ST_WAIT)  || (state == ST_WRITE);
    src_rd    = (state == ST_FETCH);
    src_addr  = src_rd ? gen_addr : '0;
    win_valid = (state == ST_WAIT);
    dst_we    = (state == ST_WRITE) && !abort_i;
    dst_addr  = (state == ST_WRITE) ? (row_base + ADDR_W'(x)) : '0;
    dst_data  = (state == ST_WRITE) ? filt_rgb_in : '0;
    done      = (state == ST_DONE);
  end

endmodule

// File: tb/tb_filter_window_sequencer.sv
module tb_filter_window_sequencer;

  localparam int unsigned W   = 3;
  localparam int unsigned H   = 3;
  localparam int unsigned AW  = 4;
  localparam int unsigned LAT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, done, src_rd, win_valid, dst_we;
  logic [AW-1:0] src_addr, dst_addr;
  logic [11:0]   src_data, filt_rgb_in, dst_data;
  logic [107:0]  win_data;
`ifdef SEQ_ABORT_EN
  logic          abort;
  logic          aborted;
`endif

  always #5 clk = ~clk;

  filter_window_sequencer #(
    .IMG_W     (W),
    .IMG_H     (H),
    .ADDR_W    (AW),
    .FILTER_LAT(LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .src_rd     (src_rd),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .win_data   (win_data),
    .win_valid  (win_valid),
    .filt_rgb_in(filt_rgb_in),
    .dst_we     (dst_we),
    .dst_addr   (dst_addr),
    .dst_data   (dst_data)
`ifdef SEQ_ABORT_EN
    ,
    .abort      (abort),
    .aborted    (aborted)
`endif
  );

  // Source RAM with one-cycle read latency.
  logic [11:0] mem [16];
  always @(posedge clk) if (src_rd) src_data <= mem[src_addr];

  // Identity effect: original pixel delayed LAT cycles.
  logic [11:0] dly [LAT];
  always @(posedge clk) begin
    dly[0] <= win_data[107:96];
    for (int i = 1; i < int'(LAT); i++) dly[i] <= dly[i-1];
  end
  assign filt_rgb_in = dly[LAT-1];

  // Negedge monitor.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            wr_n = 0, done_n = 0, rd_n = 0, win_n = 0, unstable = 0, done_cyc = 0;
  logic [AW-1:0] wr_a [128];
  logic [11:0]   wr_d [128];
  logic [AW-1:0] rd_a [1024];
  logic [107:0]  win_log [64];
  logic          wv_q = 1'b0;
  logic [107:0]  win_q = '0;

  always @(negedge clk) begin
    if (dst_we && wr_n < 128) begin
      wr_a[wr_n] = dst_addr;
      wr_d[wr_n] = dst_data;
      wr_n++;
    end
    if (src_rd && rd_n < 1024) begin
      rd_a[rd_n] = src_addr;
      rd_n++;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (win_valid && !wv_q && win_n < 64) begin
      win_log[win_n] = win_data;
      win_n++;
    end
    if (win_valid && wv_q && win_data !== win_q) unstable++;
    wv_q  = win_valid;
    win_q = win_data;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [107:0] got, input logic [107:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  int acc = 0;

  task automatic start_frame;
    tick;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc   = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_n == base && n < 400) begin
      tick;
      n++;
    end
    check("done_seen", 108'(done_n != base), 108'(1));
  endtask

  function automatic logic [107:0] pack9(input logic [11:0] o, l, r, u, d, ul, ur, dl, dr);
    return {o, l, r, u, d, ul, ur, dl, dr};
  endfunction

  function automatic logic [11:0] pat2(input int a);
    return 12'hA5C ^ 12'(a * 37);
  endfunction

  int unsigned ord [9] = '{4, 3, 5, 1, 7, 0, 2, 6, 8};
  int wb, db, rb, vb, n, rd_at_reset, hit;

  initial begin
    reset = 1'b1;
    start = 1'b0;
`ifdef SEQ_ABORT_EN
    abort = 1'b0;
`endif
    for (int a = 0; a < 16; a++) mem[a] = 12'(a + 1);

    // Reset state.
    repeat (3) tick;
    check("rst_busy",      108'(busy),      108'(0));
    check("rst_done",      108'(done),      108'(0));
    check("rst_src_rd",    108'(src_rd),    108'(0));
    check("rst_dst_we",    108'(dst_we),    108'(0));
    check("rst_win_valid", 108'(win_valid), 108'(0));
    check("rst_win_data",  win_data,        108'(0));
    check("rst_src_addr",  108'(src_addr),  108'(0));
    check("rst_dst_addr",  108'(dst_addr),  108'(0));
    reset = 1'b0;
    repeat (2) tick;
    check("idle_busy", 108'(busy), 108'(0));

    // Identity frame.
    wb = wr_n; db = done_n; rb = rd_n; vb = win_n;
    start_frame;
    check("acc_busy",     108'(busy),     108'(1));
    check("acc_src_rd",   108'(src_rd),   108'(1));
    check("acc_src_addr", 108'(src_addr), 108'(0));
    wait_done(db);
    check("f1_latency", 108'(done_cyc - acc), 108'(135));
    check("f1_done_busy", 108'(busy), 108'(0));
    repeat (3) tick;
    check("f1_writes", 108'(wr_n - wb), 108'(9));
    check("f1_done_cnt", 108'(done_n - db), 108'(1));
    check("f1_reads", 108'(rd_n - rb), 108'(81));
    for (int i = 0; i < 9; i++) begin
      check($sformatf("f1_addr%0d", i), 108'(wr_a[wb+i]), 108'(i));
      check($sformatf("f1_data%0d", i), 108'(wr_d[wb+i]), 108'(i + 1));
    end
    for (int j = 0; j < 9; j++)
      check($sformatf("rd_order%0d", j), 108'(rd_a[rb+36+j]), 108'(ord[j]));
    check("win_corner00", win_log[vb],   pack9(1, 1, 2, 1, 4, 1, 2, 4, 5));
    check("win_corner22", win_log[vb+8], pack9(9, 8, 9, 6, 9, 5, 6, 8, 9));
    check("win_stable", 108'(unstable), 108'(0));
    check("idle_win_hold", win_data, pack9(9, 8, 9, 6, 9, 5, 6, 8, 9));
    check("idle_win_valid", 108'(win_valid), 108'(0));

    // Start while busy is ignored.
    wb = wr_n; db = done_n;
    start_frame;
    repeat (19) tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(db);
    check("f2_latency", 108'(done_cyc - acc), 108'(135));
    repeat (3) tick;
    check("f2_writes", 108'(wr_n - wb), 108'(9));
    check("f2_done_cnt", 108'(done_n - db), 108'(1));
    check("f2_idle_busy", 108'(busy), 108'(0));

    // Reset mid-frame.
    wb = wr_n;
    start_frame;
    n = 0;
    while (wr_n - wb < 3 && n < 200) begin
      tick;
      n++;
    end
    check("f3_third_write", 108'(wr_n - wb), 108'(3));
    tick;
    reset = 1'b1;
    #1;
    rd_at_reset = rd_n;
    check("mid_rst_busy",   108'(busy),      108'(0));
    check("mid_rst_src_rd", 108'(src_rd),    108'(0));
    check("mid_rst_dst_we", 108'(dst_we),    108'(0));
    check("mid_rst_wv",     108'(win_valid), 108'(0));
    check("mid_rst_win",    win_data,        108'(0));
    repeat (2) tick;
    reset = 1'b0;
    repeat (40) tick;
    check("f3_no_4th_write", 108'(wr_n - wb), 108'(3));
    check("f3_no_reads",     108'(rd_n - rd_at_reset), 108'(0));

    for (int a = 0; a < 16; a++) mem[a] = pat2(a);
    wb = wr_n; db = done_n;
    start_frame;
    wait_done(db);
    repeat (2) tick;
    check("f4_writes", 108'(wr_n - wb), 108'(9));
    for (int i = 0; i < 9; i++) begin
      check($sformatf("f4_addr%0d", i), 108'(wr_a[wb+i]), 108'(i));
      check($sformatf("f4_data%0d", i), 108'(wr_d[wb+i]), 108'(pat2(i)));
    end

`ifdef SEQ_ABORT_EN
    // Abort during WAIT of pixel 2.
    for (int a = 0; a < 16; a++) mem[a] = 12'(a + 1);
    wb = wr_n; db = done_n; vb = win_n;
    start_frame;
    n = 0;
    while (win_n - vb < 3 && n < 200) begin
      tick;
      n++;
    end
    check("ab_in_wait", 108'(win_valid), 108'(1));
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("ab_busy",    108'(busy),    108'(0));
    check("ab_aborted", 108'(aborted), 108'(1));
    tick;
    tick;
    check("ab_pulse_end", 108'(aborted), 108'(0));
    repeat (40) tick;
    check("ab_writes", 108'(wr_n - wb), 108'(2));
    hit = 0;
    for (int i = wb; i < wr_n; i++) if (wr_a[i] == AW'(2)) hit++;
    check("ab_no_addr2", 108'(hit), 108'(0));
    check("ab_no_done", 108'(done_n - db), 108'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
